// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared state encoding and BCD constants for the sequential converter.
// Revision : 1.0
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// ============================================================================
// Module   : bcd_dabble_step
// Purpose  : One double-dabble step: per-digit add-3 correction, then 1-bit shift.
// Revision : 1.0
// ============================================================================
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] acc,
    input  logic                          in_bit,
    output logic [BCD_DIGIT_W*DIGITS-1:0] acc_next,
    output logic                          carry_out
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;

    logic [ACC_W-1:0] adj;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign adj[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
            (acc[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_ADJ_THRESH)
                ? acc[i*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_ADJ_ADD
                : acc[i*BCD_DIGIT_W +: BCD_DIGIT_W];
    end

    assign acc_next  = {adj[ACC_W-2:0], in_bit};
    assign carry_out = adj[ACC_W-1];

endmodule
`default_nettype wire

// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seq_converter
// Purpose  : Sequential binary-to-BCD converter, one bit per clock, valid/ready.
// Revision : 1.0
// ============================================================================
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          out_ovf,
    output logic                          busy
);

    localparam int               ACC_W    = BCD_DIGIT_W * DIGITS;
    localparam int               CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_step;
    logic [BIN_W-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             carry;
    logic             last_shift;

    bcd_dabble_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .acc       (acc),
        .in_bit    (sreg[BIN_W-1]),
        .acc_next  (acc_step),
        .carry_out (carry)
    );

    assign last_shift = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            sreg    <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_bcd <= '0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg <= in_bin;
                        acc  <= '0;
                        cnt  <= '0;
                        ovf  <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc  <= acc_step;
                    sreg <= sreg << 1;
                    cnt  <= cnt + CNT_W'(1);
                    ovf  <= ovf | carry;
                    // Result registers only move on the final shift so they hold otherwise
                    if (last_shift) begin
                        out_bcd <= acc_step;
                        out_ovf <= ovf | carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seq_converter
// Purpose  : Scoreboard bench for bcd_seq_converter (BIN_W=14, DIGITS=4).
// Revision : 1.0
// ============================================================================
module tb_bcd_seq_converter;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc_cycle;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic        out_ovf;
    logic        busy;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cycle      = 0;
    int   last_hs    = 0;
    int   last_rise  = 0;
    int   prev_rise  = 0;
    bit   prev_valid = 1'b0;
    bit   chk_b2b    = 1'b0;

    bcd_seq_converter #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int v, input int acc_cycle);
        exp_t e;
        int   r;
        e.bcd = '0;
        r     = v;
        for (int i = 0; i < DIGITS; i++) begin
            e.bcd[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e.ovf       = (v >= 10000);
        e.acc_cycle = acc_cycle;
        return e;
    endfunction

    // Monitor: inputs change just after posedge, so negedge values predict the next edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check_eq("unexpected_out_valid", 32'(out_valid), 32'd0);
                else check_eq("latency", 32'(cycle - sb[0].acc_cycle), 32'(BIN_W + 1));
                prev_rise = last_rise;
                last_rise = cycle;
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("out_bcd", 32'(out_bcd), 32'(e.bcd));
                check_eq("out_ovf", 32'(out_ovf), 32'(e.ovf));
                last_hs = cycle;
            end
            if (in_valid && in_ready) begin
                if (chk_b2b) check_eq("b2b_accept", 32'(cycle), 32'(last_hs + 1));
                sb.push_back(model(int'(in_bin), cycle));
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic send(input int v);
        int n;
        in_bin   = 14'(v);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        check_eq("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #3;
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_bcd",   32'(out_bcd),   32'h0);
        check_eq("rst_out_ovf",   32'(out_ovf),   32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(9999);
        drain();
        send(16383);
        drain();
        send(0);
        drain();

        // Stall in DONE with stray input pulses that must not be accepted
        out_ready = 1'b0;
        send(1234);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_bcd",      32'(out_bcd),   32'h1234);
            check_eq("stall_in_ready", 32'(in_ready),  32'd0);
            check_eq("stall_valid",    32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
            in_bin   = 14'd3333;
            in_valid = (i % 2 == 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Back-to-back with in_valid held high across both transfers
        send(42);
        chk_b2b = 1'b1;
        send(4095);
        chk_b2b = 1'b0;
        drain();
        check_eq("result_spacing", 32'(last_rise - prev_rise), 32'(BIN_W + 2));

        // Abort mid-conversion during the 7th SHIFT cycle
        send(777);
        repeat (6) @(posedge clk);
        #1;
        check_eq("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_eq("abort_in_ready",  32'(in_ready),  32'd1);
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_out_bcd",   32'(out_bcd),   32'h0);
        check_eq("abort_out_ovf",   32'(out_ovf),   32'd0);
        check_eq("abort_busy",      32'(busy),      32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(500);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
